// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared definitions for the NES PPU-side blocks.
//   dma_state_t  : sprite-DMA engine state encoding
//   OAMDATA_ADDR : CPU address of the PPU OAMDATA register ($2004)
//   OAMDMA_ADDR  : CPU address of the sprite-DMA trigger register ($4014)
// ---------------------------------------------------------------------------
package ppu_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;

endpackage : ppu_pkg

// File: rtl/oam_dma_engine.sv
// ---------------------------------------------------------------------------
// oam_dma_engine
// Sprite-DMA initiator. A $4014 write halts the CPU, then the engine copies
// OAM_BYTES bytes from CPU page {dmaPage, 8'h00} into OAM through $2004.
// Reads are placed on get cycles and writes on put cycles; one ALIGN cycle is
// inserted when the HALT cycle itself falls on a get cycle.
//
// Ports:
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   clock_EN     in   CPU-cycle enable; state only advances when high
//   dmaTrigger   in   CPU wrote $4014 this enabled cycle
//   dmaPage      in   [7:0] source page, sampled with dmaTrigger
//   busData_IN   in   [7:0] CPU-bus read data at the end of a READ cycle
//   cpuHalt      out  CPU RDY-low request (HALT through last WRITE)
//   busAddress   out  [15:0] DMA bus address in READ/WRITE
//   busRead      out  DMA owns the bus for a read
//   oamWrite_EN  out  OAMDATA write strobe
//   oamData_OUT  out  [7:0] byte written to OAM
//   dmaActive    out  engine is not IDLE
// ---------------------------------------------------------------------------
module oam_dma_engine
    import ppu_pkg::*;
#(
    parameter int OAM_BYTES = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clock_EN,
    input  logic        dmaTrigger,
    input  logic [7:0]  dmaPage,
    input  logic [7:0]  busData_IN,
    output logic        cpuHalt,
    output logic [15:0] busAddress,
    output logic        busRead,
    output logic        oamWrite_EN,
    output logic [7:0]  oamData_OUT,
    output logic        dmaActive
);

    localparam logic [7:0] LAST_BYTE = 8'(OAM_BYTES - 1);

    dma_state_t  state_q,       state_d;
    logic [7:0]  page_q,        page_d;
    logic [7:0]  count_q,       count_d;
    logic [7:0]  data_q,        data_d;
    logic        get_cycle_q,   get_cycle_d;

    logic        cpu_halt_q,    cpu_halt_d;
    logic [15:0] bus_address_q, bus_address_d;
    logic        bus_read_q,    bus_read_d;
    logic        oam_write_q,   oam_write_d;
    logic [7:0]  oam_data_q,    oam_data_d;
    logic        dma_active_q,  dma_active_d;

    // Next-state, page/count/data latches and get/put phase tracking.
    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        count_d     = count_q;
        data_d      = data_q;
        get_cycle_d = get_cycle_q;
        if (clock_EN) begin
            get_cycle_d = ~get_cycle_q;
            case (state_q)
                DMA_IDLE: begin
                    if (dmaTrigger) begin
                        state_d = DMA_HALT;
                        page_d  = dmaPage;
                        count_d = 8'h00;
                    end else begin
                        state_d = DMA_IDLE;
                    end
                end
                DMA_HALT: begin
                    // A HALT on a get cycle leaves the next cycle as a put,
                    // so burn one ALIGN cycle to land the first read on a get.
                    if (get_cycle_q) begin
                        state_d = DMA_ALIGN;
                    end else begin
                        state_d = DMA_READ;
                    end
                end
                DMA_ALIGN: begin
                    state_d = DMA_READ;
                end
                DMA_READ: begin
                    data_d  = busData_IN;
                    state_d = DMA_WRITE;
                end
                DMA_WRITE: begin
                    count_d = count_q + 8'd1;
                    if (count_q == LAST_BYTE) begin
                        state_d = DMA_IDLE;
                    end else begin
                        state_d = DMA_READ;
                    end
                end
                default: begin
                    state_d = DMA_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Moore output decode of the next state, so the registered outputs line
    // up exactly with the state register and freeze while clock_EN is low.
    always_comb begin
        cpu_halt_d    = 1'b0;
        bus_address_d = 16'h0000;
        bus_read_d    = 1'b0;
        oam_write_d   = 1'b0;
        oam_data_d    = 8'h00;
        dma_active_d  = 1'b0;
        case (state_d)
            DMA_IDLE: begin
                cpu_halt_d   = 1'b0;
                dma_active_d = 1'b0;
            end
            DMA_HALT, DMA_ALIGN: begin
                cpu_halt_d   = 1'b1;
                dma_active_d = 1'b1;
            end
            DMA_READ: begin
                cpu_halt_d    = 1'b1;
                dma_active_d  = 1'b1;
                bus_read_d    = 1'b1;
                bus_address_d = {page_d, count_d};
            end
            DMA_WRITE: begin
                cpu_halt_d    = 1'b1;
                dma_active_d  = 1'b1;
                oam_write_d   = 1'b1;
                bus_address_d = OAMDATA_ADDR;
                oam_data_d    = data_d;
            end
            default: begin
                cpu_halt_d   = 1'b0;
                dma_active_d = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= DMA_IDLE;
            page_q        <= 8'h00;
            count_q       <= 8'h00;
            data_q        <= 8'h00;
            get_cycle_q   <= 1'b1;
            cpu_halt_q    <= 1'b0;
            bus_address_q <= 16'h0000;
            bus_read_q    <= 1'b0;
            oam_write_q   <= 1'b0;
            oam_data_q    <= 8'h00;
            dma_active_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            page_q        <= page_d;
            count_q       <= count_d;
            data_q        <= data_d;
            get_cycle_q   <= get_cycle_d;
            cpu_halt_q    <= cpu_halt_d;
            bus_address_q <= bus_address_d;
            bus_read_q    <= bus_read_d;
            oam_write_q   <= oam_write_d;
            oam_data_q    <= oam_data_d;
            dma_active_q  <= dma_active_d;
        end
    end

    assign cpuHalt     = cpu_halt_q;
    assign busAddress  = bus_address_q;
    assign busRead     = bus_read_q;
    assign oamWrite_EN = oam_write_q;
    assign oamData_OUT = oam_data_q;
    assign dmaActive   = dma_active_q;

endmodule : oam_dma_engine

// File: tb/tb_oam_dma_engine.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_engine
// Directed bench for the sprite-DMA engine. The CPU bus is modelled as a
// fixed function of the address; each scenario task drives a transfer and
// checks every cycle against the expected HALT/ALIGN/READ/WRITE sequence.
// ---------------------------------------------------------------------------
module tb_oam_dma_engine;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clock_EN;
    logic        dmaTrigger;
    logic [7:0]  dmaPage;
    logic [7:0]  busData_IN;
    logic        cpuHalt;
    logic [15:0] busAddress;
    logic        busRead;
    logic        oamWrite_EN;
    logic [7:0]  oamData_OUT;
    logic        dmaActive;

    int n_checks = 0;
    int n_fail   = 0;
    int n_en     = 0;   // enabled cycles since reset (even => get cycle)

    always #5 clock = ~clock;

    // Simple RAM contents model: a fixed scramble of the address.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
    endfunction

    assign busData_IN = mem_f(busAddress);

    oam_dma_engine #(.OAM_BYTES(256)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clock_EN    (clock_EN),
        .dmaTrigger  (dmaTrigger),
        .dmaPage     (dmaPage),
        .busData_IN  (busData_IN),
        .cpuHalt     (cpuHalt),
        .busAddress  (busAddress),
        .busRead     (busRead),
        .oamWrite_EN (oamWrite_EN),
        .oamData_OUT (oamData_OUT),
        .dmaActive   (dmaActive)
    );

    task automatic tick(input logic en);
        clock_EN = en;
        @(posedge clock);
        if (en) n_en++;
        @(negedge clock);
    endtask

    // Trigger a transfer from 'page' and follow it cycle by cycle.
    // stop_byte >= 0 returns as soon as the READ of that byte is on the bus.
    task automatic run_transfer(input logic [7:0] page, input bit gaps,
                                input bit retrig, input int stop_byte);
        bit   align;
        int   total, off, k, j, iter;
        int   halt_cnt, rd_cnt, wr_cnt, idle_halt_cnt;
        bit   is_rd, is_wr;
        logic en;
        // Trigger on a put cycle => HALT on a get cycle => one ALIGN cycle.
        align = (n_en % 2) == 1;
        total = align ? 514 : 513;
        off   = align ? 2 : 1;
        halt_cnt = 0; rd_cnt = 0; wr_cnt = 0; idle_halt_cnt = 0;
        dmaPage = page; dmaTrigger = 1'b1;
        tick(1'b1);
        dmaTrigger = 1'b0; dmaPage = 8'h00;
        k = 0; iter = 0;
        while (k < total && iter < 4000) begin
            iter++;
            is_rd = 1'b0; is_wr = 1'b0; j = 0;
            if (k >= off) begin
                j     = (k - off) / 2;
                is_rd = ((k - off) % 2) == 0;
                is_wr = !is_rd;
            end
            if (stop_byte >= 0 && is_rd && j == stop_byte) return;
            n_checks += 4;
            if (cpuHalt !== 1'b1) begin
                n_fail++; $display("FAIL cpuHalt k=%0d got %b want 1", k, cpuHalt);
            end
            if (dmaActive !== 1'b1) begin
                n_fail++; $display("FAIL dmaActive k=%0d got %b want 1", k, dmaActive);
            end
            if (busRead !== is_rd) begin
                n_fail++; $display("FAIL busRead k=%0d got %b want %b", k, busRead, is_rd);
            end
            if (oamWrite_EN !== is_wr) begin
                n_fail++; $display("FAIL oamWrite_EN k=%0d got %b want %b", k, oamWrite_EN, is_wr);
            end
            if (is_rd) begin
                n_checks++;
                if (busAddress !== {page, 8'(j)}) begin
                    n_fail++; $display("FAIL read_addr k=%0d got %h want %h", k, busAddress, {page, 8'(j)});
                end
            end
            if (is_wr) begin
                n_checks += 2;
                if (busAddress !== 16'h2004) begin
                    n_fail++; $display("FAIL write_addr k=%0d got %h want 2004", k, busAddress);
                end
                if (oamData_OUT !== mem_f({page, 8'(j)})) begin
                    n_fail++; $display("FAIL oam_data byte=%0d got %h want %h", j, oamData_OUT, mem_f({page, 8'(j)}));
                end
            end
            en = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (retrig && is_rd && j == 100) begin
                dmaTrigger = 1'b1; dmaPage = 8'h07;
            end
            if (en) begin
                if (cpuHalt) halt_cnt++;
                if (busRead) rd_cnt++;
                if (oamWrite_EN) wr_cnt++;
                if (cpuHalt && !busRead && !oamWrite_EN) idle_halt_cnt++;
            end
            tick(en);
            dmaTrigger = 1'b0; dmaPage = 8'h00;
            if (en) k++;
        end
        n_checks += 9;
        if (iter >= 4000) begin
            n_fail++; $display("FAIL timeout k=%0d got %0d cycles want %0d", k, iter, total);
        end
        if (cpuHalt !== 1'b0 || dmaActive !== 1'b0) begin
            n_fail++; $display("FAIL end_idle got halt=%b active=%b want 0 0", cpuHalt, dmaActive);
        end
        if (busRead !== 1'b0 || oamWrite_EN !== 1'b0) begin
            n_fail++; $display("FAIL end_strobes got rd=%b wr=%b want 0 0", busRead, oamWrite_EN);
        end
        if (halt_cnt != total) begin
            n_fail++; $display("FAIL halt_cycles got %0d want %0d", halt_cnt, total);
        end
        if (rd_cnt != 256) begin
            n_fail++; $display("FAIL read_count got %0d want 256", rd_cnt);
        end
        if (wr_cnt != 256) begin
            n_fail++; $display("FAIL write_count got %0d want 256", wr_cnt);
        end
        if (idle_halt_cnt != (align ? 2 : 1)) begin
            n_fail++; $display("FAIL halt_align_cycles got %0d want %0d", idle_halt_cnt, align ? 2 : 1);
        end
        // One more enabled idle cycle: must stay idle.
        tick(1'b1);
        if (cpuHalt !== 1'b0) begin
            n_fail++; $display("FAIL stay_idle got %b want 0", cpuHalt);
        end
        if (dmaActive !== 1'b0) begin
            n_fail++; $display("FAIL stay_idle_active got %b want 0", dmaActive);
        end
    endtask

    task automatic test_reset();
        n_checks += 6;
        if (cpuHalt !== 1'b0)      begin n_fail++; $display("FAIL reset_cpuHalt got %b want 0", cpuHalt); end
        if (busRead !== 1'b0)      begin n_fail++; $display("FAIL reset_busRead got %b want 0", busRead); end
        if (oamWrite_EN !== 1'b0)  begin n_fail++; $display("FAIL reset_oamWrite got %b want 0", oamWrite_EN); end
        if (dmaActive !== 1'b0)    begin n_fail++; $display("FAIL reset_dmaActive got %b want 0", dmaActive); end
        if (busAddress !== 16'h0)  begin n_fail++; $display("FAIL reset_busAddress got %h want 0000", busAddress); end
        if (oamData_OUT !== 8'h0)  begin n_fail++; $display("FAIL reset_oamData got %h want 00", oamData_OUT); end
        // Triggerless idle cycles must not start anything.
        tick(1'b1); tick(1'b1);
        n_checks++;
        if (cpuHalt !== 1'b0) begin n_fail++; $display("FAIL idle_no_trigger got %b want 0", cpuHalt); end
    endtask

    task automatic test_halt_on_put();
        if (n_en % 2 == 1) tick(1'b1);
        run_transfer(8'h02, 1'b0, 1'b0, -1);
    endtask

    task automatic test_halt_on_get();
        if (n_en % 2 == 0) tick(1'b1);
        run_transfer(8'h02, 1'b0, 1'b0, -1);
    endtask

    task automatic test_retrigger();
        if (n_en % 2 == 1) tick(1'b1);
        run_transfer(8'h02, 1'b0, 1'b1, -1);
    endtask

    task automatic test_gaps();
        tick(1'b0); tick(1'b1); tick(1'b0);
        run_transfer(8'h02, 1'b1, 1'b0, -1);
        run_transfer(8'h5A, 1'b1, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        run_transfer(8'h02, 1'b0, 1'b0, 40);
        n_checks++;
        if (busAddress !== 16'h0228) begin
            n_fail++; $display("FAIL pre_reset_addr got %h want 0228", busAddress);
        end
        reset_n = 1'b0;
        #1;
        n_checks += 6;
        if (cpuHalt !== 1'b0)      begin n_fail++; $display("FAIL midreset_cpuHalt got %b want 0", cpuHalt); end
        if (busRead !== 1'b0)      begin n_fail++; $display("FAIL midreset_busRead got %b want 0", busRead); end
        if (oamWrite_EN !== 1'b0)  begin n_fail++; $display("FAIL midreset_oamWrite got %b want 0", oamWrite_EN); end
        if (dmaActive !== 1'b0)    begin n_fail++; $display("FAIL midreset_dmaActive got %b want 0", dmaActive); end
        if (busAddress !== 16'h0)  begin n_fail++; $display("FAIL midreset_busAddress got %h want 0000", busAddress); end
        if (oamData_OUT !== 8'h0)  begin n_fail++; $display("FAIL midreset_oamData got %h want 00", oamData_OUT); end
        @(negedge clock);
        reset_n = 1'b1;
        n_en = 0;
        run_transfer(8'h02, 1'b0, 1'b0, -1);
    endtask

    task automatic test_page_ff();
        run_transfer(8'hFF, 1'b0, 1'b0, -1);
    endtask

    initial begin
        reset_n    = 1'b0;
        clock_EN   = 1'b0;
        dmaTrigger = 1'b0;
        dmaPage    = 8'h00;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        n_en = 0;
        test_reset();
        test_halt_on_put();
        test_halt_on_get();
        test_retrigger();
        test_gaps();
        test_reset_mid();
        test_page_ff();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_oam_dma_engine
